// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU pipeline requesters, the unified memory and the
// port arbiter.
//   slave  : the arbiter's view. Requests and memory responses come in;
//            acks, read data and the memory command go out.
//   master : the environment's view (pipeline requesters plus the memory),
//            with every direction reversed.
// Signals:
//   if_req/if_addr -> if_rdata/if_ack            fetch requester
//   d_req/d_we/d_addr/d_wdata/d_be -> d_rdata/d_ack   data requester
//   err                                          timeout flag, set with an ack
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be      memory command
//   mem_rdata/mem_ready                          memory response
//   busy                                         arbiter is not idle
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
    output if_rdata, if_ack, d_rdata, d_ack, err,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, err,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch (IF) and data (MEM).
// Data wins conflicts until STREAK_MAX data grants have been made in a row.
// After that, a pending fetch wins the next conflict.
// An access waits for mem_ready. If mem_ready does not arrive within MAX_WAIT
// cycles, the access is forced to complete with err set.
// Ports:
//   clkin : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mem_port_arbiter_if.slave. All outputs come straight from flops.
module mem_port_arbiter #(
  parameter int MAX_WAIT   = 16,
  parameter int STREAK_MAX = 4
) (
  input  logic              clkin,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT);
  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(MAX_WAIT - 1);
  localparam logic [SW-1:0] STREAK_TOP  = SW'(STREAK_MAX);
  localparam logic [31:0]   TIMEOUT_DAT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC} state_t;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  typedef struct packed {
    logic        if_ack;
    logic        d_ack;
    logic        err;
    logic [31:0] if_rdata;
    logic [31:0] d_rdata;
  } rsp_t;

  state_t        state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic [SW-1:0] streak, streak_n;
  mem_req_t      mreq, mreq_n;
  rsp_t          rsp, rsp_n;
  logic          busy_q, busy_n;
  logic          d_wins, done;
  logic [31:0]   rd_word;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      streak   <= '0;
      mreq     <= '0;
      rsp      <= '0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      streak   <= streak_n;
      mreq     <= mreq_n;
      rsp      <= rsp_n;
      busy_q   <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    streak_n = streak;
    mreq_n  = mreq;
    rsp_n   = rsp;
    // ack and err are single-cycle pulses, so they clear unless set below.
    rsp_n.if_ack = 1'b0;
    rsp_n.d_ack  = 1'b0;
    rsp_n.err    = 1'b0;
    // A saturated streak hands the conflict to fetch.
    d_wins  = bus.d_req && !(bus.if_req && streak == STREAK_TOP);
    // Finish on mem_ready, or on the last allowed wait cycle (timeout).
    done    = bus.mem_ready || (wait_cnt == WAIT_LAST);
    rd_word = bus.mem_ready ? bus.mem_rdata : TIMEOUT_DAT;

    case (state)
      IDLE: begin
        if (d_wins) begin
          state_n  = D_ACC;
          mreq_n   = '{en: 1'b1, we: bus.d_we, addr: bus.d_addr,
                       wdata: bus.d_wdata, be: bus.d_be};
          wait_n   = '0;
          streak_n = (streak == STREAK_TOP) ? streak : streak + 1'b1;
        end else if (bus.if_req) begin
          state_n  = IF_ACC;
          mreq_n   = '{en: 1'b1, we: 1'b0, addr: bus.if_addr,
                       wdata: 32'h0, be: 4'hF};
          wait_n   = '0;
          streak_n = '0;
        end
      end
      IF_ACC, D_ACC: begin
        if (done) begin
          state_n   = IDLE;
          mreq_n.en = 1'b0;
          mreq_n.we = 1'b0;
          rsp_n.err = !bus.mem_ready;
          if (state == IF_ACC) begin
            rsp_n.if_ack   = 1'b1;
            rsp_n.if_rdata = rd_word;
          end else begin
            rsp_n.d_ack = 1'b1;
            // On a write, d_rdata keeps its previous value.
            if (!mreq.we) rsp_n.d_rdata = rd_word;
          end
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.mem_en    = mreq.en;
  assign bus.mem_we    = mreq.we;
  assign bus.mem_addr  = mreq.addr;
  assign bus.mem_wdata = mreq.wdata;
  assign bus.mem_be    = mreq.be;
  assign bus.if_ack    = rsp.if_ack;
  assign bus.if_rdata  = rsp.if_rdata;
  assign bus.d_ack     = rsp.d_ack;
  assign bus.d_rdata   = rsp.d_rdata;
  assign bus.err       = rsp.err;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// The bench drives and samples 1 time unit after each rising edge.
// A transaction-level model predicts, for each access:
//   - the winner (from the streak rule),
//   - the command fields on the memory port,
//   - the completion cycle,
//   - err and the read data.
module tb_mem_port_arbiter;
  localparam int MAX_WAIT   = 16;
  localparam int STREAK_MAX = 4;

  logic clkin = 1'b0;
  logic reset = 1'b0;
  always #5 clkin = ~clkin;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .STREAK_MAX(STREAK_MAX)) dut (
    .clkin (clkin),
    .reset (reset),
    .bus   (bus)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  int          m_streak = 0;
  logic [31:0] m_if_rdata = 32'h0;
  logic [31:0] m_d_rdata  = 32'h0;
  bit          last_dwin;
  logic [9:0]  seq10;
  logic [4:0]  seq5;

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Runs one access from IDLE and checks it against the model.
  // waits = number of ACC cycles with mem_ready low before it rises.
  // If waits >= MAX_WAIT, mem_ready never rises and the access times out.
  task automatic do_txn(input bit ir, input bit dr, input bit we,
                        input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int waits, input logic [31:0] rd);
    bit          dwin, tmo, ewe;
    int          nacc;
    logic [31:0] ea, ewd, rv;
    logic [3:0]  ebe;
    dwin     = dr && !(ir && m_streak == STREAK_MAX);
    m_streak = dwin ? ((m_streak < STREAK_MAX) ? m_streak + 1 : STREAK_MAX) : 0;
    ea  = dwin ? da : ia;
    ewe = dwin && we;
    ebe = dwin ? be : 4'hF;
    ewd = dwin ? wd : 32'h0;
    tmo  = (waits >= MAX_WAIT);
    nacc = tmo ? MAX_WAIT : waits + 1;
    rv   = tmo ? 32'hDEAD_BEEF : rd;
    if (!dwin) m_if_rdata = rv;
    else if (!we) m_d_rdata = rv;

    bus.if_req  = ir;
    bus.d_req   = dr;
    bus.d_we    = we;
    bus.if_addr = ia;
    bus.d_addr  = da;
    bus.d_wdata = wd;
    bus.d_be    = be;
    bus.mem_ready = 1'($urandom_range(0, 1));  // must be ignored in IDLE
    bus.mem_rdata = $urandom;
    tick();
    chk("grant_en_busy", 32'({bus.mem_en, bus.busy}), 32'h3);
    chk("grant_addr", bus.mem_addr, ea);
    chk("grant_we_be", 32'({bus.mem_we, bus.mem_be}), 32'({ewe, ebe}));
    chk("grant_wdata", bus.mem_wdata, ewd);
    chk("grant_no_ack", 32'({bus.if_ack, bus.d_ack, bus.err}), 32'h0);

    for (int c = 0; c < nacc; c++) begin
      bus.mem_ready = (c == waits);
      bus.mem_rdata = (c == waits) ? rd : $urandom;
      tick();
      if (c < nacc - 1) begin
        chk("acc_cmd", 32'({bus.mem_en, bus.mem_we, bus.mem_be}), 32'({1'b1, ewe, ebe}));
        chk("acc_addr", bus.mem_addr, ea);
        chk("acc_wdata", bus.mem_wdata, ewd);
        chk("acc_no_ack", 32'({bus.if_ack, bus.d_ack, bus.err}), 32'h0);
      end else begin
        chk("done_acks", 32'({bus.if_ack, bus.d_ack}), 32'({!dwin, dwin}));
        chk("done_err", 32'(bus.err), 32'(tmo));
        chk("done_if_rdata", bus.if_rdata, m_if_rdata);
        chk("done_d_rdata", bus.d_rdata, m_d_rdata);
        chk("done_idle", 32'({bus.busy, bus.mem_en, bus.mem_we}), 32'h0);
      end
    end
    last_dwin = bus.d_ack;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0;  bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_ctl", 32'({bus.mem_en, bus.mem_we, bus.busy, bus.if_ack, bus.d_ack, bus.err}), 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_rdata", bus.if_rdata | bus.d_rdata | bus.mem_wdata, 32'h0);
    reset = 1'b1;

    // mem_ready in IDLE with no request has no effect
    bus.mem_ready = 1'b1;
    tick();
    chk("idle_ready", 32'({bus.busy, bus.mem_en, bus.if_ack, bus.d_ack}), 32'h0);
    bus.mem_ready = 1'b0;

    // 1: single fetch
    do_txn(1, 0, 0, 32'h0040_0000, 32'h0, 32'h0, 4'h0, 0, 32'h2008_0005);
    chk("t1_if_rdata", bus.if_rdata, 32'h2008_0005);

    // 3: back-to-back conflict, mem_ready always 1
    for (int i = 0; i < 10; i++) begin
      do_txn(1, 1, 0, 32'h0040_0100 + 32'(4 * i), 32'h1000_0000 + 32'(4 * i),
             32'h0, 4'hF, 0, $urandom);
      seq10[9 - i] = last_dwin;
    end
    chk("t3_order", 32'(seq10), 32'(10'b1111011110));

    // 2: data write, three wait states
    do_txn(0, 1, 1, 32'h0, 32'h1000_0004, 32'hCAFE_1234, 4'b0011, 3, 32'h1111_2222);

    // 4: data read timeout
    do_txn(0, 1, 0, 32'h0, 32'h1000_0040, 32'h0, 4'hF, MAX_WAIT, 32'h5555_5555);
    chk("t4_deadbeef", bus.d_rdata, 32'hDEAD_BEEF);

    // 5: reset during a data access
    bus.if_req = 1'b0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1000_0080;
    bus.mem_ready = 1'b0;
    tick();
    chk("t5_in_acc", 32'({bus.busy, bus.mem_en}), 32'h3);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_ctl", 32'({bus.mem_en, bus.mem_we, bus.busy, bus.if_ack, bus.d_ack, bus.err}), 32'h0);
    chk("t5_async_data", bus.mem_addr | bus.d_rdata | bus.if_rdata | bus.mem_wdata, 32'h0);
    bus.d_req = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    m_streak = 0; m_if_rdata = 32'h0; m_d_rdata = 32'h0;
    chk("t5_no_ack", 32'({bus.d_ack, bus.if_ack, bus.busy}), 32'h0);
    for (int i = 0; i < 5; i++) begin
      do_txn(1, 1, 1, 32'h0040_0200, 32'h1000_0100, 32'h1234_0000 + 32'(i), 4'hC, 0, $urandom);
      seq5[4 - i] = last_dwin;
    end
    chk("t5_streak0", 32'(seq5), 32'(5'b11110));
    do_txn(1, 0, 0, 32'h0040_0300, 32'h0, 32'h0, 4'h0, 1, 32'h0BAD_F00D);

    // Randomised accesses: mixed requesters, wait states, occasional timeouts
    for (int i = 0; i < 40; i++) begin
      bit ir, dr, we;
      int w;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) dr = 1'b1;
      we = 1'($urandom_range(0, 1));
      w  = ($urandom_range(0, 7) == 0) ? MAX_WAIT + int'($urandom_range(0, 3))
                                       : int'($urandom_range(0, 4));
      do_txn(ir, dr, we, $urandom, $urandom, $urandom, 4'($urandom), w, $urandom);
    end

    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
    chk("end_idle", 32'({bus.busy, bus.mem_en, bus.if_ack, bus.d_ack, bus.err}), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
